// File: rtl/if_id_queue.sv
// Fetch queue between IF and ID: buffers {PC, instruction} pairs so fetch can run ahead of decode.
// Full-queue stall comes from registered occupancy only; a flush discards every buffered entry.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Flush,
    input  logic                       Push_Valid,
    input  logic [WIDTH-1:0]           Push_PC,
    input  logic [WIDTH-1:0]           Push_Instr,
    output logic                       Fetch_Stall,
    input  logic                       Pop_Ready,
    output logic                       Out_Valid,
    output logic [WIDTH-1:0]           Out_PC,
    output logic [WIDTH-1:0]           Out_Instr,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push_acc;
    logic             pop_acc;

    assign Fetch_Stall = (count_q == CW'(DEPTH));
    assign Out_Valid   = (count_q != '0);
    assign Count       = count_q;

    assign push_acc = Push_Valid & ~Fetch_Stall & ~Flush;
    assign pop_acc  = Pop_Ready & Out_Valid & ~Flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_acc)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_acc && !pop_acc)
                count_q <= count_q + CW'(1);
            else if (pop_acc && !push_acc)
                count_q <= count_q - CW'(1);
        end
    end

    // Storage is left unreset; outputs are masked whenever the queue is empty.
    always_ff @(posedge Clk) begin
        if (push_acc) begin
            mem_pc[wr_ptr]    <= Push_PC;
            mem_instr[wr_ptr] <= Push_Instr;
        end
    end

    assign Out_PC    = Out_Valid ? mem_pc[rd_ptr]    : '0;
    assign Out_Instr = Out_Valid ? mem_instr[rd_ptr] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue: reset, fill/drain, streaming,
// full-with-pop, flush and pop-while-empty scenarios with hand-computed expectations.
module tb_if_id_queue;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Flush = 1'b0;
    logic        Push_Valid = 1'b0;
    logic [31:0] Push_PC = '0;
    logic [31:0] Push_Instr = '0;
    logic        Fetch_Stall;
    logic        Pop_Ready = 1'b0;
    logic        Out_Valid;
    logic [31:0] Out_PC;
    logic [31:0] Out_Instr;
    logic [2:0]  Count;

    int n_total = 0;
    int n_bad   = 0;

    if_id_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Flush       (Flush),
        .Push_Valid  (Push_Valid),
        .Push_PC     (Push_PC),
        .Push_Instr  (Push_Instr),
        .Fetch_Stall (Fetch_Stall),
        .Pop_Ready   (Pop_Ready),
        .Out_Valid   (Out_Valid),
        .Out_PC      (Out_PC),
        .Out_Instr   (Out_Instr),
        .Count       (Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so inputs change and outputs are sampled off-edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_count", 32'(Count), 0);
        chk("rst_valid", 32'(Out_Valid), 0);
        chk("rst_stall", 32'(Fetch_Stall), 0);
        chk("rst_pc", Out_PC, 0);
        chk("rst_instr", Out_Instr, 0);
        Rst = 1'b0;

        Push_Valid = 1'b1; Push_PC = 32'h0; Push_Instr = 32'h2008_0005;
        cyc();
        chk("first_valid", 32'(Out_Valid), 1);
        chk("first_pc", Out_PC, 32'h0);
        chk("first_instr", Out_Instr, 32'h2008_0005);
        chk("first_count", 32'(Count), 1);
        Push_PC = 32'h4; Push_Instr = 32'h11;
        cyc();
        chk("two_count", 32'(Count), 2);
        Push_Valid = 1'b0;

        // Asynchronous reset between edges
        #2 Rst = 1'b1;
        #1;
        chk("arst_count", 32'(Count), 0);
        chk("arst_valid", 32'(Out_Valid), 0);
        chk("arst_instr", Out_Instr, 0);
        Rst = 1'b0;

        // Fill to DEPTH, attempt a fifth push, then drain in order
        for (int i = 0; i < 4; i++) begin
            Push_Valid = 1'b1; Push_PC = 32'(4 * i); Push_Instr = 32'hA000_0000 | 32'(i);
            cyc();
        end
        chk("fill_count", 32'(Count), 4);
        chk("fill_stall", 32'(Fetch_Stall), 1);
        Push_PC = 32'h10; Push_Instr = 32'hDEAD_BEEF;
        cyc();
        Push_Valid = 1'b0;
        chk("over_count", 32'(Count), 4);
        chk("over_head", Out_PC, 32'h0);
        Pop_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", Out_PC, 32'(4 * i));
            chk("drain_instr", Out_Instr, 32'hA000_0000 | 32'(i));
            cyc();
            if (i == 0) chk("drain_stall_fall", 32'(Fetch_Stall), 0);
        end
        Pop_Ready = 1'b0;
        chk("drain_valid", 32'(Out_Valid), 0);
        chk("drain_instr0", Out_Instr, 0);
        chk("drain_count", 32'(Count), 0);

        // Streaming push+pop every cycle; crosses pointer wrap
        Push_Valid = 1'b1; Pop_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Push_PC = 32'h100 + 32'(4 * i); Push_Instr = 32'hB0 + 32'(i);
            cyc();
            chk("stream_count", 32'(Count), 1);
            chk("stream_stall", 32'(Fetch_Stall), 0);
            chk("stream_pc", Out_PC, 32'h100 + 32'(4 * i));
            chk("stream_instr", Out_Instr, 32'hB0 + 32'(i));
        end
        Push_Valid = 1'b0;
        cyc();
        chk("stream_end", 32'(Count), 0);
        Pop_Ready = 1'b0;

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) begin
            Push_Valid = 1'b1; Push_PC = 32'(4 * i); Push_Instr = 32'hC0 + 32'(i);
            cyc();
        end
        Push_PC = 32'h10; Push_Instr = 32'hC4; Pop_Ready = 1'b1;
        cyc();
        chk("fullpop_count", 32'(Count), 3);
        chk("fullpop_stall", 32'(Fetch_Stall), 0);
        chk("fullpop_head", Out_PC, 32'h4);
        Pop_Ready = 1'b0;
        cyc();
        chk("retry_count", 32'(Count), 4);
        chk("retry_stall", 32'(Fetch_Stall), 1);
        Push_Valid = 1'b0; Pop_Ready = 1'b1;
        cyc();
        chk("pre_flush_count", 32'(Count), 3);
        chk("pre_flush_head", Out_PC, 32'h8);

        // Flush beats simultaneous push and pop
        Flush = 1'b1; Push_Valid = 1'b1; Push_PC = 32'h20; Push_Instr = 32'h220;
        cyc();
        Flush = 1'b0; Pop_Ready = 1'b0;
        chk("flush_count", 32'(Count), 0);
        chk("flush_valid", 32'(Out_Valid), 0);
        chk("flush_pc", Out_PC, 0);
        Push_PC = 32'h40; Push_Instr = 32'h440;
        cyc();
        Push_Valid = 1'b0;
        chk("post_flush_pc", Out_PC, 32'h40);
        chk("post_flush_instr", Out_Instr, 32'h440);
        chk("post_flush_count", 32'(Count), 1);
        Pop_Ready = 1'b1;
        cyc();
        chk("post_flush_pop", 32'(Count), 0);

        // Pop while empty, then confirm data still lines up
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("empty_pop_count", 32'(Count), 0);
        end
        Push_Valid = 1'b1; Push_PC = 32'h80; Push_Instr = 32'h880;
        cyc();
        chk("nobypass_count", 32'(Count), 1);
        chk("nobypass_pc", Out_PC, 32'h80);
        Push_PC = 32'h84; Push_Instr = 32'h884;
        cyc();
        Push_Valid = 1'b0;
        chk("after_empty_pc", Out_PC, 32'h84);
        chk("after_empty_instr", Out_Instr, 32'h884);
        chk("after_empty_count", 32'(Count), 1);
        cyc();
        Pop_Ready = 1'b0;
        chk("final_count", 32'(Count), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue between the program counter register / instruction memory (IF) and the decode stage (ID) of the five-stage pipeline. It buffers up to DEPTH fetched {PC, instruction} pairs so that fetch can run ahead of decode while decode is held by hazards. It generates the stall that freezes the PC register when the queue is full. It discards all buffered wrong-path instructions when a taken branch or jump flushes the front end.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- WIDTH, 32, width of the PC and instruction fields

- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- Flush  in  1  taken branch/jump resolved in ID; discards all entries
- Push_Valid  in  1  fetch presents a valid instruction this cycle
- Push_PC  in  WIDTH  PC of the fetched instruction
- Push_Instr  in  WIDTH  fetched instruction word
- Fetch_Stall  out  1  queue full; drives the PC register Stall input
- Pop_Ready  in  1  decode consumes the head entry this cycle (ID not stalled)
- Out_Valid  out  1  head entry present
- Out_PC  out  WIDTH  PC of head entry; 0 when empty
- Out_Instr  out  WIDTH  head instruction; 0 (NOP) when empty
- Count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Circular buffer with write pointer, read pointer and occupancy count.
- Both pointers wrap modulo DEPTH.
- Fetch_Stall = (Count == DEPTH). It is derived from registered state only, with no combinational path from any input.
- Push accepted = Push_Valid & !Fetch_Stall & !Flush.
  - Writes {Push_PC, Push_Instr} at the write pointer and increments it.
  - A push while full is ignored. The PC is stalled that cycle, so the same instruction is refetched.
- Pop accepted = Pop_Ready & Out_Valid & !Flush.
  - Increments the read pointer.
  - Pop while empty is ignored; Count never underflows.
- Simultaneous accepted push and pop: Count unchanged, both pointers advance.
- A push while full is rejected even if a pop occurs in the same cycle. The freed slot becomes usable the next cycle.
- Flush has highest priority. On the next edge:
  - both pointers and Count go to 0;
  - any push or pop in the same cycle is discarded;
  - Out_Valid is 0 the cycle after the flush edge.
- Out_Valid = (Count != 0).
- Out_PC and Out_Instr show the entry at the read pointer when Out_Valid = 1, and are forced to 0 otherwise.
- Storage contents are not reset; empty-state masking guarantees defined outputs.

## Timing
- Reset (asynchronous, immediate, independent of Clk):
  - pointers = 0, Count = 0;
  - Out_Valid = 0, Fetch_Stall = 0, Out_PC = 0, Out_Instr = 0.
- Rst asserted mid-operation drops all entries immediately. The first push after Rst deasserts is accepted on the next rising edge.
- Latency: an instruction pushed at edge N appears on Out_* with Out_Valid = 1 after edge N. Decode can pop it at edge N+1. There is no same-cycle bypass while empty.
- Fetch_Stall rises in the cycle after the push that fills the queue. It falls in the cycle after the first accepted pop or flush.
- Throughput: one push and one pop per cycle sustained when 0 < Count < DEPTH.
- Ordering: strict FIFO; the PC sequence out equals the accepted PC sequence in.

## Test plan
- Reset: assert Rst between edges → outputs go to 0 without a clock edge. Release, push PC = 0x00000000 / Instr = 0x20080005 → Out_Valid = 1 and Out_PC = 0 after one edge.
- Fill: push 0x0, 0x4, 0x8, 0xC with Pop_Ready = 0 → Count = 4, Fetch_Stall = 1. A fifth push of 0x10 is ignored. Pop four times → PCs 0x0, 0x4, 0x8, 0xC in order, then Out_Valid = 0 and Out_Instr = 0.
- Streaming: Push_Valid = 1 and Pop_Ready = 1 every cycle for 10 cycles with PC incrementing by 4 → Count stays 1 and Fetch_Stall stays 0. Output PC lags input by one cycle; wrap-around occurs with no loss.
- Full plus simultaneous pop: at Count = 4, assert Pop_Ready and Push_Valid (PC 0x10) together → pop accepted, push rejected, Count = 3. Next cycle the push of 0x10 is accepted → Count = 4.
- Flush: Count = 3, assert Flush together with Push_Valid (0x20) and Pop_Ready → next cycle Count = 0 and Out_Valid = 0. Entry 0x20 never appears. The following push of 0x40 becomes the head.
- Pop when empty: Pop_Ready = 1 with Count = 0 for 3 cycles → Count stays 0 and pointers unchanged. A subsequent push/pop returns the correct data.
